uart_recv: RTL and testbench

UART receive block, the counterpart of the UART transmitter on the same serial link.
- Frame format: 8N1, LSB first.
- Synchronises the asynchronous uart_rxd line and confirms the start bit at mid-bit.
- Samples each data bit at its centre and checks the stop bit.
- Presents each received byte with a one-cycle valid pulse; a bad stop bit gives a one-cycle frame-error pulse instead.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_recv.sv | 115 +++++++++++
 tb/tb_uart_recv.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and the
// baud divider calculation used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int   DATA_BITS = 8;
    localparam logic UART_IDLE = 1'b1;

    function automatic int calc_bps_cnt(input int clk_freq, input int bps);
        return clk_freq / bps;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial input plus a history flop
// for falling-edge detection; everything resets to the idle-high line level.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rx_s,
    output logic rx_fall
);

    logic rx_s1;
    logic rx_s2;
    logic rx_s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= UART_IDLE;
            rx_s2 <= UART_IDLE;
            rx_s3 <= UART_IDLE;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_s    = rx_s2;
    assign rx_fall = rx_s3 & ~rx_s2;

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: confirms the start bit at mid-bit, samples each data bit
// at its centre, and reports a byte (uart_done) or a bad stop bit (frame_err).
module uart_recv
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 9600
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       uart_rxd,
    output logic [7:0] uart_data,
    output logic       uart_done,
    output logic       frame_err,
    output logic       uart_rx_busy
);

    localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
    localparam logic [15:0] HALF_END = 16'(BPS_CNT / 2 - 1);
    localparam logic [15:0] BIT_END  = 16'(BPS_CNT - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    if (BPS_CNT < 8) begin : g_bps_check
        $error("uart_recv: CLK_FREQ/UART_BPS must be at least 8");
    end

    rx_state_t            state;
    rx_state_t            next_state;
    logic [15:0]          clk_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rx_s;
    logic                 rx_fall;
    logic                 half_hit;
    logic                 bit_hit;

    uart_rx_sync u_sync (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .rxd     (uart_rxd),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        half_hit     = (clk_cnt == HALF_END);
        bit_hit      = (clk_cnt == BIT_END);
        uart_rx_busy = (state != IDLE);
        case (state)
            IDLE: begin
                if (rx_fall) next_state = START;
            end
            START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (half_hit) next_state = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (bit_hit && bit_cnt == LAST_BIT) next_state = STOP;
            end
            STOP: begin
                // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                if (bit_hit) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            uart_data <= '0;
            uart_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            uart_done <= 1'b0;
            frame_err <= 1'b0;

            if (state == IDLE || next_state != state || (state == DATA && bit_hit)) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 16'd1;
            end

            if (state == START) begin
                bit_cnt <= '0;
            end

            if (state == DATA && bit_hit) begin
                shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end

            if (state == STOP && bit_hit) begin
                if (rx_s) begin
                    uart_data <= shift_reg;
                    uart_done <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_recv.sv
// Randomised and directed bench for uart_recv: a queue of expected frame
// outcomes is built from the bytes and stop bits sent on the line.
module tb_uart_recv;

    localparam int CLK_FREQ = 1600;
    localparam int UART_BPS = 100;
    localparam int BIT_T    = CLK_FREQ / UART_BPS;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic       sys_clk;
    logic       sys_rst;
    logic       uart_rxd;
    logic [7:0] uart_data;
    logic       uart_done;
    logic       frame_err;
    logic       uart_rx_busy;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] last_good;
    int         check_count;
    int         error_count;
    int         busy_len;
    int         last_busy_len;
    int         busy_starts;
    bit         busy_prev;
    int         err_pulses;
    int         starts_before;
    int         errs_before;

    uart_recv #(
        .CLK_FREQ (CLK_FREQ),
        .UART_BPS (UART_BPS)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .uart_rxd     (uart_rxd),
        .uart_data    (uart_data),
        .uart_done    (uart_done),
        .frame_err    (frame_err),
        .uart_rx_busy (uart_rx_busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Every uart_done / frame_err pulse is matched against the oldest expected outcome.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            busy_len  = 0;
            busy_prev = 1'b0;
        end else begin
            if (uart_rx_busy) begin
                busy_len++;
            end else if (busy_len != 0) begin
                last_busy_len = busy_len;
                busy_len      = 0;
            end
            if (uart_rx_busy && !busy_prev) busy_starts++;
            busy_prev = uart_rx_busy;
            if (frame_err) err_pulses++;

            if (uart_done && frame_err) begin
                checkOutput("done_err_exclusive", 32'd1, 32'd0);
            end else if (uart_done || frame_err) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_pulse", {30'd0, frame_err, uart_done}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("pulse_kind", {31'd0, frame_err}, {31'd0, mon_e.is_err});
                    if (mon_e.is_err) begin
                        checkOutput("data_held_on_err", {24'd0, uart_data}, {24'd0, last_good});
                    end else begin
                        checkOutput("rx_data", {24'd0, uart_data}, {24'd0, mon_e.data});
                        last_good = mon_e.data;
                    end
                end
            end
        end
    end

    task automatic idleLine(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit stop);
        exp_t e;
        e.is_err = !stop;
        e.data   = stop ? b : 8'h00;
        exp_q.push_back(e);
        uart_rxd = 1'b0;
        repeat (BIT_T) @(negedge sys_clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (BIT_T) @(negedge sys_clk);
        end
        uart_rxd = stop;
        repeat (BIT_T) @(negedge sys_clk);
    endtask

    task automatic drainQueue(input string tag);
        for (int i = 0; i < 20 * BIT_T; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge sys_clk);
        end
        checkOutput(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rb;
        bit         rs;
        check_count   = 0;
        error_count   = 0;
        busy_starts   = 0;
        err_pulses    = 0;
        last_busy_len = 0;
        last_good     = 8'h00;
        sys_rst       = 1'b1;
        uart_rxd      = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        checkOutput("reset_busy", {31'd0, uart_rx_busy}, 32'd0);
        checkOutput("reset_data", {24'd0, uart_data}, 32'd0);
        checkOutput("reset_done", {31'd0, uart_done}, 32'd0);
        checkOutput("reset_err", {31'd0, frame_err}, 32'd0);
        idleLine(2 * BIT_T);

        $display("[TB] single frame 0x55");
        applyStimulus(8'h55, 1'b1);
        drainQueue("drain_single");
        idleLine(BIT_T);
        checkOutput("busy_len_frame", last_busy_len, 32'd152);

        $display("[TB] back-to-back 0xA5, 0x3C");
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(8'h3C, 1'b1);
        drainQueue("drain_b2b");
        idleLine(BIT_T);

        $display("[TB] start glitch then 0x0F");
        starts_before = busy_starts;
        uart_rxd = 1'b0;
        repeat (4) @(negedge sys_clk);
        idleLine(2 * BIT_T);
        checkOutput("glitch_busy_len", last_busy_len, 32'd8);
        checkOutput("glitch_busy_once", busy_starts - starts_before, 32'd1);
        checkOutput("glitch_idle", {31'd0, uart_rx_busy}, 32'd0);
        applyStimulus(8'h0F, 1'b1);
        drainQueue("drain_glitch");
        idleLine(BIT_T);

        $display("[TB] bad stop bit then 0x7E");
        applyStimulus(8'h81, 1'b0);
        idleLine(2 * BIT_T);
        applyStimulus(8'h7E, 1'b1);
        drainQueue("drain_ferr");
        idleLine(BIT_T);

        $display("[TB] reset during data bit 3 of 0xC3");
        uart_rxd = 1'b0;
        repeat (BIT_T) @(negedge sys_clk);
        for (int i = 0; i < 3; i++) begin
            uart_rxd = (8'hC3 >> i) & 8'h01;
            repeat (BIT_T) @(negedge sys_clk);
        end
        uart_rxd = 1'b0;
        repeat (BIT_T / 2) @(negedge sys_clk);
        uart_rxd = 1'b1;
        sys_rst  = 1'b1;
        @(negedge sys_clk);
        sys_rst   = 1'b0;
        last_good = 8'h00;
        checkOutput("midreset_busy", {31'd0, uart_rx_busy}, 32'd0);
        checkOutput("midreset_data", {24'd0, uart_data}, 32'd0);
        checkOutput("midreset_done", {31'd0, uart_done}, 32'd0);
        idleLine(20 * BIT_T);
        checkOutput("midreset_quiet", {31'd0, uart_rx_busy}, 32'd0);
        applyStimulus(8'h99, 1'b1);
        drainQueue("drain_reset");
        idleLine(BIT_T);

        $display("[TB] break of 30 bit times then 0x42");
        starts_before = busy_starts;
        errs_before   = err_pulses;
        exp_q.push_back('{is_err: 1'b1, data: 8'h00});
        uart_rxd = 1'b0;
        repeat (30 * BIT_T) @(negedge sys_clk);
        checkOutput("break_err_once", err_pulses - errs_before, 32'd1);
        checkOutput("break_one_frame", busy_starts - starts_before, 32'd1);
        checkOutput("break_idle", {31'd0, uart_rx_busy}, 32'd0);
        idleLine(2 * BIT_T);
        applyStimulus(8'h42, 1'b1);
        drainQueue("drain_break");
        idleLine(BIT_T);

        $display("[TB] random frames");
        for (int n = 0; n < 10; n++) begin
            rb = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            applyStimulus(rb, rs);
            idleLine($urandom_range(1, 2 * BIT_T));
        end
        drainQueue("drain_random");
        idleLine(BIT_T);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
